alu_md: RTL and testbench
=========================

# alu_md

Parametrised, handshaked execute unit for the RISC-V core. It implements the RV32I integer ALU operations plus the RV32M multiply/divide operations at a configurable datapath width XLEN. ALU operations complete in one cycle; multiply and divide run iteratively. It sits between decode/operand-select, which chooses reg, imm or pc for the operands, and writeback. It uses valid/ready handshakes on both sides, carries a tag through, and supports a flush.

## Interface
- XLEN, 32, datapath width; power of 2, ≥ 8; SH = log2(XLEN)
- TAG_W, 5, width of the pass-through tag (e.g. rd index)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; abort any in-flight or pending result
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- op  in  5  operation code (see Operation)
- a  in  XLEN  operand A (rs1 or pc)
- b  in  XLEN  operand B (rs2 or imm)
- in_tag  in  TAG_W  tag captured with the operation
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result
- out_tag  out  TAG_W  tag of the result

## Operation
- op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (result = b, used for LUI)
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - any other code: result 0, ALU latency
- Shifts use b[SH-1:0] only. SRA replicates a[XLEN-1].
- SLT is a signed compare; SLTU is unsigned. Result is {0…, bit}.
- MUL* forms the 2·XLEN product of sign/zero-extended operands:
  - MULH is signed × signed.
  - MULHSU is signed a × unsigned b.
  - MULHU is unsigned × unsigned.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Multiply is an iterative shift-add: 1 bit per cycle, XLEN iterations, on magnitudes with a final sign fix.
- Divide is restoring: 1 quotient bit per cycle, XLEN iterations, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Divide by zero: the quotient is all ones (DIV, DIVU); the remainder is a (REM, REMU). The latency is unchanged.
- Signed overflow (a = most negative, b = −1): DIV → a, REM → 0. The latency is unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on accept of an ALU op → DONE with the result registered. On accept of an M op → BUSY with counter = XLEN−1.
  - BUSY: counter decrements each cycle; at 0 → DONE with the result registered.
  - DONE: out_valid = 1. On out_ready, either accept a new op with the same IDLE rules, or go → IDLE if none is offered.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Accept = in_valid & in_ready. op, a, b and in_tag are captured only on accept.
- result and out_tag are stable while out_valid & !out_ready.

## Timing
- Reset (async, rst_n low): state IDLE; out_valid 0; result 0; out_tag 0; counter 0.
  - in_ready = 1 once in IDLE.
  - Reset mid-BUSY or mid-DONE discards the operation; nothing is emitted.
- ALU op accepted at edge N: out_valid = 1 from cycle N+1.
- M op accepted at edge N: BUSY for cycles N+1…N+XLEN; out_valid = 1 from cycle N+XLEN+1.
- Back-to-back ALU ops with out_ready held at 1: one result per cycle.
- Back-to-back M ops: one result per XLEN+1 cycles.
- flush (highest priority after reset): next state IDLE, out_valid 0, no accept that cycle. result and out_tag keep their values.
- Simultaneous out_ready & in_valid in DONE: the old result retires and the new op is captured in the same edge. out_valid stays 1 for an ALU op; it drops to 0 for an M op.
- All arithmetic is modulo 2^XLEN. The product register is 2·XLEN wide. The divide remainder register is XLEN+1 wide.

## Test plan
- Reset, then ADD a=0xFFFFFFFF, b=1, tag=3 → out_valid at N+1, result 0x00000000, out_tag 3; SUB 0 − 1 → 0xFFFFFFFF.
- SRA a=0x80000000, b=0x24 (shamt 4) → 0xF8000000. SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0.
- MULH a=b=0x80000000 → 0x40000000 with out_valid exactly at N+33. MUL 7 × −3 → 0xFFFFFFEB. MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
- DIV 7 / 0 → 0xFFFFFFFF; REM 7 / 0 → 7; DIV 0x80000000 / −1 → 0x80000000; REM of the same → 0; DIV −7 / 2 → −3; REM −7 / 2 → −1.
- Back-pressure: hold out_ready = 0 for 5 cycles after a result → result and out_tag stable, in_ready = 0. Then out_ready = 1 with in_valid → retire and accept in one edge.
- Flush at cycle N+10 of a DIVU → IDLE next cycle, no out_valid, a new ADD completes normally. rst_n pulse mid-MUL → out_valid 0, result 0, immediately.

Source files
------------

// File: rtl/alu_md.sv
// alu_md -- handshaked RV32I/RV32M execute unit, XLEN-wide datapath.
// ALU ops finish in one cycle. MUL*/DIV*/REM* run iteratively for XLEN
// cycles on operand magnitudes and apply a sign fix on the last step.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   flush                    sync abort of any in-flight/pending result
//   in_valid/in_ready        request handshake (op, a, b, in_tag)
//   out_valid/out_ready      response handshake (result, out_tag)
module alu_md #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int SH = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB  = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3,
                         OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                         OP_OR  = 5'd8,  OP_AND = 5'd9, OP_PASSB = 5'd10;

  state_e            state_q, state_d;
  logic [SH-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2:0]        mop_q, mop_d;   // low bits of the M opcode
  logic [XLEN:0]     acc_q, acc_d;   // product high half / divide remainder
  logic [XLEN-1:0]   lo_q, lo_d;     // multiplier->product low / dividend->quotient
  logic [XLEN-1:0]   opd_q, opd_d;   // multiplicand magnitude / divisor magnitude
  logic [XLEN-1:0]   a_q, a_d;       // original a, needed for remainder of x/0
  logic              neg_q, neg_d;   // sign to apply to the selected final value
  logic              divz_q, divz_d;

  // ---------------- single-cycle ALU ----------------
  logic [SH-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  assign shamt = b[SH-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_SLL:   alu_res = a << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:   alu_res = a ^ b;
      OP_SRL:   alu_res = a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(a) >>> shamt);
      OP_OR:    alu_res = a | b;
      OP_AND:   alu_res = a & b;
      OP_PASSB: alu_res = b;
      default:  alu_res = '0;
    endcase
  end

  // ---------------- M-op operand preparation ----------------
  logic            is_m, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  assign is_m   = (op[4:3] == 2'b10);
  assign is_div = op[2];
  // signed a: MULH, MULHSU, DIV, REM; signed b: MULH, DIV, REM.
  // MUL takes the unsigned path: the low half is sign-agnostic.
  assign a_sgn  = (op[2:0] == 3'd1) | (op[2:0] == 3'd2) | (op[2:0] == 3'd4) | (op[2:0] == 3'd6);
  assign b_sgn  = (op[2:0] == 3'd1) | (op[2:0] == 3'd4) | (op[2:0] == 3'd6);
  assign a_neg  = a_sgn & a[XLEN-1];
  assign b_neg  = b_sgn & b[XLEN-1];
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;

  // ---------------- iterative step ----------------
  logic [XLEN:0]     mul_sum, div_sh, div_diff, acc_n;
  logic [XLEN-1:0]   lo_n, quo, rem, m_res;
  logic [2*XLEN-1:0] prod, prod_f;

  always_comb begin
    mul_sum  = {1'b0, acc_q[XLEN-1:0]} + ({1'b0, opd_q} & {(XLEN+1){lo_q[0]}});
    div_sh   = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opd_q};
    if (mop_q[2]) begin
      // restoring: keep the difference only when it did not go negative
      acc_n = div_diff[XLEN] ? div_sh : div_diff;
      lo_n  = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      acc_n = {1'b0, mul_sum[XLEN:1]};
      lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {acc_n[XLEN-1:0], lo_n};
    prod_f = neg_q ? (~prod + 1'b1) : prod;
    quo    = neg_q ? (~lo_n + 1'b1) : lo_n;
    rem    = neg_q ? (~acc_n[XLEN-1:0] + 1'b1) : acc_n[XLEN-1:0];
    // signed overflow (MIN / -1) falls out naturally: |q| = 2^(XLEN-1), rem 0
    case (mop_q)
      3'd0:         m_res = prod_f[XLEN-1:0];
      3'd4, 3'd5:   m_res = divz_q ? '1 : quo;
      3'd6, 3'd7:   m_res = divz_q ? a_q : rem;
      default:      m_res = prod_f[2*XLEN-1:XLEN];
    endcase
  end

  // ---------------- control ----------------
  logic accept;
  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign out_tag   = tag_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    tag_d   = tag_q;
    mop_d   = mop_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    a_d     = a_q;
    neg_d   = neg_q;
    divz_d  = divz_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_BUSY) begin
      acc_d = acc_n;
      lo_d  = lo_n;
      cnt_d = cnt_q - SH'(1);
      if (cnt_q == '0) begin
        state_d = S_DONE;
        res_d   = m_res;
        cnt_d   = '0;
      end
    end else if (accept) begin
      tag_d = in_tag;
      if (is_m) begin
        state_d = S_BUSY;
        cnt_d   = SH'(XLEN-1);
        mop_d   = op[2:0];
        acc_d   = '0;
        a_d     = a;
        divz_d  = is_div & (b == '0);
        opd_d   = is_div ? b_mag : a_mag;
        lo_d    = is_div ? a_mag : b_mag;
        neg_d   = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
      end else begin
        state_d = S_DONE;
        res_d   = alu_res;
      end
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      mop_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      mop_q   <= mop_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opd_q   <= opd_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      divz_q  <= divz_d;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md (XLEN=32): hand-computed vectors, latency,
// back-pressure, back-to-back issue, flush and mid-operation reset.
module tb_alu_md;
  localparam int XLEN = 32, TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]       op;
  logic [XLEN-1:0]  a, b, result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_cmp = 0, n_bad = 0;

  alu_md #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, measure cycles to out_valid, check, then retire.
  task automatic run_op(input string nm, input logic [4:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] t,
                        input logic [31:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    op = o; a = av; b = bv; in_tag = t; in_valid = 1'b1; out_ready = 1'b0;
    chk({nm, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 100);
    chk({nm, ".lat"}, 32'(cyc), 32'(lat));
    chk({nm, ".res"}, result, exp);
    chk({nm, ".tag"}, 32'(out_tag), 32'(t));
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; in_tag = '0;
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.res",   result, 32'd0);
    chk("rst.tag",   32'(out_tag), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // ALU vectors
    run_op("add",   5'd0,  32'hFFFFFFFF, 32'h1, 5'd3, 32'h00000000, 1);
    run_op("sub",   5'd1,  32'h0, 32'h1, 5'd4, 32'hFFFFFFFF, 1);
    run_op("sra",   5'd7,  32'h80000000, 32'h24, 5'd5, 32'hF8000000, 1);
    run_op("srl",   5'd6,  32'h80000000, 32'h24, 5'd5, 32'h08000000, 1);
    run_op("sll",   5'd2,  32'h00000003, 32'h3F, 5'd6, 32'h80000000, 1);
    run_op("slt",   5'd3,  32'hFFFFFFFF, 32'h1, 5'd7, 32'h1, 1);
    run_op("sltu",  5'd4,  32'hFFFFFFFF, 32'h1, 5'd8, 32'h0, 1);
    run_op("and",   5'd9,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd9, 32'h00F000F0, 1);
    run_op("passb", 5'd10, 32'h12345678, 32'hABCDE000, 5'd10, 32'hABCDE000, 1);
    run_op("bad",   5'd11, 32'h5, 32'h6, 5'd11, 32'h0, 1);

    // Multiply
    run_op("mulh",   5'd17, 32'h80000000, 32'h80000000, 5'd12, 32'h40000000, 33);
    run_op("mul",    5'd16, 32'h7, 32'hFFFFFFFD, 5'd13, 32'hFFFFFFEB, 33);
    run_op("mulhu",  5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFE, 33);
    run_op("mulhsu", 5'd18, 32'hFFFFFFFF, 32'h2, 5'd15, 32'hFFFFFFFF, 33);

    // Divide
    run_op("div0",   5'd20, 32'h7, 32'h0, 5'd16, 32'hFFFFFFFF, 33);
    run_op("rem0",   5'd22, 32'h7, 32'h0, 5'd17, 32'h7, 33);
    run_op("divu0",  5'd21, 32'h7, 32'h0, 5'd17, 32'hFFFFFFFF, 33);
    run_op("divov",  5'd20, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 33);
    run_op("remov",  5'd22, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h0, 33);
    run_op("divneg", 5'd20, 32'hFFFFFFF9, 32'h2, 5'd20, 32'hFFFFFFFD, 33);
    run_op("remneg", 5'd22, 32'hFFFFFFF9, 32'h2, 5'd21, 32'hFFFFFFFF, 33);
    run_op("divu",   5'd21, 32'd100, 32'd7, 5'd22, 32'd14, 33);
    run_op("remu",   5'd23, 32'd100, 32'd7, 5'd23, 32'd2, 33);

    // Back-to-back ALU ops, out_ready held high: one result per cycle
    @(negedge clk);
    op = 5'd8; a = 32'h1; b = 32'h2; in_tag = 5'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b0.v", 32'(out_valid), 32'd1); chk("b2b0.r", result, 32'h3);
    chk("b2b0.t", 32'(out_tag), 32'd1);
    a = 32'h4; b = 32'h8; in_tag = 5'd2;
    @(negedge clk);
    chk("b2b1.v", 32'(out_valid), 32'd1); chk("b2b1.r", result, 32'hC);
    chk("b2b1.t", 32'(out_tag), 32'd2);
    a = 32'h10; b = 32'h20; in_tag = 5'd3;
    @(negedge clk);
    chk("b2b2.v", 32'(out_valid), 32'd1); chk("b2b2.r", result, 32'h30);
    chk("b2b2.t", 32'(out_tag), 32'd3);
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;

    // Back-pressure: result held for 5 cycles, then retire+accept in one edge
    @(negedge clk);
    op = 5'd0; a = 32'd5; b = 32'd6; in_tag = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.v",   32'(out_valid), 32'd1);
      chk("bp.r",   result, 32'd11);
      chk("bp.t",   32'(out_tag), 32'd7);
      chk("bp.rdy", 32'(in_ready), 32'd0);
    end
    op = 5'd5; a = 32'hF0; b = 32'hFF; in_tag = 5'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("bp2.v", 32'(out_valid), 32'd1);
    chk("bp2.r", result, 32'h0F);
    chk("bp2.t", 32'(out_tag), 32'd9);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // Retire-and-accept of an M op drops out_valid until the op finishes
    @(negedge clk);
    op = 5'd0; a = 32'd1; b = 32'd1; in_tag = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 5'd21; a = 32'd9; b = 32'd3; in_tag = 5'd2; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rm.v", 32'(out_valid), 32'd0);
    seen = 0;
    while (!out_valid && seen < 100) begin @(negedge clk); seen++; end
    chk("rm.lat", 32'(seen), 32'd32);
    chk("rm.r", result, 32'd3);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // Flush at cycle N+10 of a DIVU
    @(negedge clk);
    op = 5'd21; a = 32'd100; b = 32'd7; in_tag = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    chk("fl.busy", 32'(out_valid), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("fl.v",   32'(out_valid), 32'd0);
    chk("fl.rdy", 32'(in_ready), 32'd1);
    chk("fl.r",   result, 32'd3);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("fl.none", 32'(seen), 32'd0);
    run_op("postfl", 5'd0, 32'd2, 32'd3, 5'd6, 32'd5, 1);

    // Reset pulse mid-MUL
    @(negedge clk);
    op = 5'd16; a = 32'd3; b = 32'd4; in_tag = 5'd8; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr.v", 32'(out_valid), 32'd0);
    chk("mr.r", result, 32'd0);
    chk("mr.t", 32'(out_tag), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("mr.none", 32'(seen), 32'd0);
    run_op("postrst", 5'd16, 32'd3, 32'd4, 5'd9, 32'd12, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
